fetch_pc_unit: RTL and testbench

- Instruction-fetch and program-counter stage for the MIPS core.
- It sits directly upstream of control_unit and decode.
- It fetches a word from instruction memory through a req/ack handshake and presents it to decode with a valid/ready handshake.
- When decode retires the instruction, it consumes control_unit's Jump/Beq/Bne outputs, the ALU zero flag and the operand fields, then loads the next PC.

---
 rtl/mips_pkg.sv | 10 +
 rtl/next_pc_logic.sv | 29 ++
 rtl/fetch_pc_unit.sv | 75 +++++++
 tb/tb_fetch_pc_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared jump encodings, fetch state encoding and reset PC for the MIPS core
package mips_pkg;
   localparam logic [1:0] JMP_SEQ = 2'd0;
   localparam logic [1:0] JMP_J   = 2'd1;
   localparam logic [1:0] JMP_JR  = 2'd2;
   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection for jump, jr, beq/bne and sequential flow
module next_pc_logic
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  Jump,
   input  logic        Beq,
   input  logic        Bne,
   input  logic        zero,
   input  logic [15:0] imm,
   input  logic [25:0] jaddr,
   input  logic [31:0] rs_data,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        misalign
);
   logic [31:0] br_off;
   logic        taken;
   assign pc_plus4 = pc + 32'd4;
   assign br_off   = {{14{imm[15]}}, imm, 2'b00};
   // beq and bne together is illegal and falls back to sequential flow
   assign taken    = ~(Beq & Bne) & ((Beq & zero) | (Bne & ~zero));
   assign misalign = (Jump == JMP_JR) && (rs_data[1:0] != 2'b00);
   always_comb begin
      next_pc = Jump == JMP_J  ? {pc_plus4[31:28], jaddr, 2'b00} :
                Jump == JMP_JR ? {rs_data[31:2], 2'b00} :
                taken          ? pc_plus4 + br_off : pc_plus4;
   end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction fetch FSM, program counter, retired counter and jr misalignment flag
module fetch_pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       Jump,
   input  logic             Beq,
   input  logic             Bne,
   input  logic             zero,
   input  logic [15:0]      imm,
   input  logic [25:0]      jaddr,
   input  logic [31:0]      rs_data,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             jr_misalign
);
   logic [1:0]  state, next_state;
   logic [31:0] next_pc;
   logic        misalign, retire, accept;
   next_pc_logic u_next_pc (
      .pc       (pc),
      .Jump     (Jump),
      .Beq      (Beq),
      .Bne      (Bne),
      .zero     (zero),
      .imm      (imm),
      .jaddr    (jaddr),
      .rs_data  (rs_data),
      .next_pc  (next_pc),
      .pc_plus4 (pc_plus4),
      .misalign (misalign)
   );
   assign imem_addr = pc;
   assign accept    = (state == FETCH) && imem_ack;
   assign retire    = (state == HOLD) && instr_ready;
   // an unused encoding recovers through BOOT
   always_comb begin
      next_state = state == BOOT  ? FETCH :
                   state == FETCH ? (imem_ack ? HOLD : FETCH) :
                   state == HOLD  ? (instr_ready ? FETCH : HOLD) : BOOT;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         retired_cnt <= '0;
         jr_misalign <= 1'b0;
      end else begin
         state       <= next_state;
         imem_req    <= next_state == FETCH;
         instr_valid <= next_state == HOLD;
         if (accept) instr <= imem_rdata;
         if (retire) begin
            pc          <= next_pc;
            retired_cnt <= retired_cnt + CNT_W'(1);
            if (misalign) jr_misalign <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven next-PC vectors plus handshake corner sequences, with an address scoreboard
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  Jump = 2'd0;
   logic        Beq = 1'b0, Bne = 1'b0, zero = 1'b0;
   logic [15:0] imm = 16'd0;
   logic [25:0] jaddr = 26'd0;
   logic [31:0] rs_data = 32'd0;
   logic        imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0, jr_misalign;
   logic [31:0] imem_addr, imem_rdata = 32'd0, instr, pc, pc_plus4, retired_cnt;

   int checks = 0, errors = 0;
   int exp_cnt = 0;
   logic [31:0] addr_q[$];

   fetch_pc_unit dut (
      .clk(clk), .rst(rst), .Jump(Jump), .Beq(Beq), .Bne(Bne), .zero(zero),
      .imm(imm), .jaddr(jaddr), .rs_data(rs_data), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc(pc), .pc_plus4(pc_plus4), .retired_cnt(retired_cnt), .jr_misalign(jr_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] setup;
      logic [1:0]  jump;
      logic        beq, bne, z;
      logic [15:0] im;
      logic [25:0] ja;
      logic [31:0] rs;
      logic [31:0] exp;
   } vec_t;
   vec_t v[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h req=%h", name, act, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] word, input int delay);
      int n = 0;
      logic [31:0] ea;
      while (!imem_req && n < 20) begin @(negedge clk); n++; end
      chk("req_seen", {31'd0, imem_req}, 32'd1);
      if (addr_q.size() == 0) begin
         chk("queue_empty", 32'd0, 32'd1);
         ea = 32'hx;
      end else ea = addr_q.pop_front();
      chk("imem_addr", imem_addr, ea);
      chk("pc_plus4", pc_plus4, ea + 32'd4);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("req_stable", {31'd0, imem_req}, 32'd1);
         chk("addr_stable", imem_addr, ea);
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, word);
      chk("req_in_hold", {31'd0, imem_req}, 32'd0);
   endtask

   task automatic retire(input logic [1:0] j, input logic b, input logic bn, input logic z,
                         input logic [15:0] im, input logic [25:0] ja, input logic [31:0] rs,
                         input logic [31:0] exp);
      Jump = j; Beq = b; Bne = bn; zero = z; imm = im; jaddr = ja; rs_data = rs;
      instr_ready = 1'b1;
      addr_q.push_back(exp);
      @(negedge clk);
      instr_ready = 1'b0;
      Jump = 2'd0; Beq = 1'b0; Bne = 1'b0; zero = 1'b0; imm = 16'd0; jaddr = 26'd0; rs_data = 32'd0;
      exp_cnt++;
      chk("retired_cnt", retired_cnt, exp_cnt);
      chk("valid_after_ready", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      v[0] = '{32'h0000_0010, 2'd0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 26'd0, 32'd0, 32'h0000_000C};
      v[1] = '{32'h0000_0010, 2'd0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'd0, 32'd0, 32'h0000_0014};
      v[2] = '{32'h0000_0010, 2'd0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 32'h0000_000C};
      v[3] = '{32'h1000_0040, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0, 26'h100, 32'd0, 32'h1000_0400};
      v[4] = '{32'h1000_0040, 2'd1, 1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h100, 32'd0, 32'h1000_0400};
      v[5] = '{32'h0000_0010, 2'd0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 26'd0, 32'd0, 32'h0000_0014};
      v[6] = '{32'h0000_0010, 2'd3, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h3FF, 32'h40, 32'h0000_0014};
      v[7] = '{32'hFFFF_FFFC, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'h0000_0000};
      v[8] = '{32'h0000_0100, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0010, 26'd0, 32'd0, 32'h0000_0144};
      v[9] = '{32'hFFFF_FFF0, 2'd0, 1'b1, 1'b0, 1'b1, 16'h0004, 26'd0, 32'd0, 32'h0000_0004};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      chk("boot_valid", {31'd0, instr_valid}, 32'd0);
      chk("boot_cnt", retired_cnt, 32'd0);
      chk("boot_misalign", {31'd0, jr_misalign}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);

      addr_q.push_back(32'd0);
      fetch(32'h2008_0005, 0);
      retire(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'd4);

      for (int i = 0; i < 10; i++) begin
         fetch(32'h1000_0000 + i, 0);
         retire(2'd2, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, v[i].setup, v[i].setup);
         fetch(32'h2000_0000 + i, 0);
         retire(v[i].jump, v[i].beq, v[i].bne, v[i].z, v[i].im, v[i].ja, v[i].rs, v[i].exp);
         chk("misalign_clear", {31'd0, jr_misalign}, 32'd0);
      end

      fetch(32'h0060_0008, 0);
      retire(2'd2, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'h0000_0203, 32'h0000_0200);
      chk("misalign_set", {31'd0, jr_misalign}, 32'd1);

      fetch(32'hAAAA_5555, 3);
      for (int i = 0; i < 5; i++) begin
         imem_ack = (i == 2);
         imem_rdata = 32'h1234_5678;
         @(negedge clk);
         chk("hold_instr", instr, 32'hAAAA_5555);
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_cnt", retired_cnt, exp_cnt);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
      end
      imem_ack = 1'b0;
      retire(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'h0000_0204);
      chk("misalign_sticky", {31'd0, jr_misalign}, 32'd1);

      fetch(32'h5555_AAAA, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_valid_async", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc_async", pc, 32'd0);
      chk("rst_misalign", {31'd0, jr_misalign}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("boot_ack_ignored", {31'd0, instr_valid}, 32'd0);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_instr", instr, 32'd0);
      chk("post_rst_cnt", retired_cnt, 32'd0);
      chk("queue_drained", addr_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
